// File: rtl/vedic_pkg.sv
// Shared constants for the multiplier-sharing arbiter: default sizes and FSM state encoding.
package vedic_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 2;
    localparam int CNT_W_DEF   = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request found searching from ptr_i upwards, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    always_comb begin
        int   idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Shares one external multiplier among NUM_REQ requesters, one transaction in flight at a time.
// Handshakes: a transfer happens on a rising edge where tvalid and tready are both high.
module vedic_mul_arbiter
    import vedic_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [NUM_REQ-1:0]    req_tvalid,
    output logic [NUM_REQ-1:0]    req_tready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_tdata,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_tdata,
    output logic [NUM_REQ-1:0]    rsp_tvalid,
    input  logic [NUM_REQ-1:0]    rsp_tready,
    output logic [2*DATA_W-1:0]   rsp_tdata,
    output logic [DATA_W-1:0]     mul_a_tdata,
    output logic                  mul_a_tvalid,
    input  logic                  mul_a_tready,
    output logic [DATA_W-1:0]     mul_b_tdata,
    output logic                  mul_b_tvalid,
    input  logic                  mul_b_tready,
    input  logic [2*DATA_W-1:0]   mul_result_tdata,
    input  logic                  mul_result_tvalid,
    output logic                  mul_result_tready,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_count,
    output logic [1:0]            dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic                a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [2*DATA_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [PTR_W-1:0]    next_ptr;
    logic                rsp_hs;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req_i (req_tvalid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_a = req_a_tdata[i*DATA_W +: DATA_W];
                sel_b = req_b_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves one past the requester just served.
    always_comb begin
        next_ptr = '0;
        for (int i = 0; i < NUM_REQ - 1; i++) begin
            if (grant_q[i]) next_ptr = PTR_W'(i + 1);
        end
    end

    assign rsp_hs = |(rsp_tready & grant_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        a_vld_d = a_vld_q;
        b_vld_d = b_vld_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_tvalid) begin
                    grant_d = arb_gnt;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    a_vld_d = 1'b1;
                    b_vld_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                a_vld_d = a_vld_q & ~mul_a_tready;
                b_vld_d = b_vld_q & ~mul_b_tready;
                if (!a_vld_d && !b_vld_d) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_result_tvalid) begin
                    res_d   = mul_result_tdata;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only req_tready is combinational; it is forced low while reset is held.
    assign req_tready        = (state_q == ST_IDLE) ? (arb_gnt & {NUM_REQ{arst_n}}) : '0;
    assign mul_a_tdata       = a_q;
    assign mul_a_tvalid      = a_vld_q;
    assign mul_b_tdata       = b_q;
    assign mul_b_tvalid      = b_vld_q;
    assign mul_result_tready = (state_q == ST_WAIT);
    assign rsp_tvalid        = (state_q == ST_RESPOND) ? grant_q : '0;
    assign rsp_tdata         = res_q;
    assign busy              = (state_q != ST_IDLE);
    assign done_count        = cnt_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Directed and randomized bench for vedic_mul_arbiter with an external multiplier model.
module tb_vedic_mul_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic           clk;
    logic           arst_n;
    logic [N-1:0]   req_tvalid, req_tready;
    logic [N*W-1:0] req_a_tdata, req_b_tdata;
    logic [N-1:0]   rsp_tvalid, rsp_tready;
    logic [2*W-1:0] rsp_tdata;
    logic [W-1:0]   mul_a_tdata, mul_b_tdata;
    logic           mul_a_tvalid, mul_a_tready, mul_b_tvalid, mul_b_tready;
    logic [2*W-1:0] mul_result_tdata;
    logic           mul_result_tvalid, mul_result_tready;
    logic           busy;
    logic [15:0]    done_count;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_ptr = 0;
    int m_done = 0;
    int winner = 0;
    logic [2*W-1:0] exp_q[$];

    // multiplier-side observation
    int a_hs = 0;
    int b_hs = 0;
    logic [W-1:0] a_cap = '0;
    logic [W-1:0] b_cap = '0;

    vedic_mul_arbiter #(.NUM_REQ(N), .DATA_W(W), .CNT_W(16)) dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .req_tvalid        (req_tvalid),
        .req_tready        (req_tready),
        .req_a_tdata       (req_a_tdata),
        .req_b_tdata       (req_b_tdata),
        .rsp_tvalid        (rsp_tvalid),
        .rsp_tready        (rsp_tready),
        .rsp_tdata         (rsp_tdata),
        .mul_a_tdata       (mul_a_tdata),
        .mul_a_tvalid      (mul_a_tvalid),
        .mul_a_tready      (mul_a_tready),
        .mul_b_tdata       (mul_b_tdata),
        .mul_b_tvalid      (mul_b_tvalid),
        .mul_b_tready      (mul_b_tready),
        .mul_result_tdata  (mul_result_tdata),
        .mul_result_tvalid (mul_result_tvalid),
        .mul_result_tready (mul_result_tready),
        .busy              (busy),
        .done_count        (done_count),
        .dbg_state         (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_a_tvalid && mul_a_tready) begin
            a_hs  = a_hs + 1;
            a_cap = mul_a_tdata;
        end
        if (mul_b_tvalid && mul_b_tready) begin
            b_hs  = b_hs + 1;
            b_cap = mul_b_tdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int p);
        for (int k = 0; k < N; k++) begin
            if (mask[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_state"}, dbg_state, 0);
        chk({tag, "_req_tready"}, req_tready, 0);
        chk({tag, "_rsp_tvalid"}, rsp_tvalid, 0);
        chk({tag, "_rsp_tdata"}, rsp_tdata, 0);
        chk({tag, "_mul_a"}, {mul_a_tvalid, mul_a_tdata}, 0);
        chk({tag, "_mul_b"}, {mul_b_tvalid, mul_b_tdata}, 0);
        chk({tag, "_res_ready"}, mul_result_tready, 0);
        chk({tag, "_done"}, done_count, 0);
    endtask

    task automatic idle_inputs();
        req_tvalid = '0;
        rsp_tready = '0;
        mul_a_tready = 1'b0;
        mul_b_tready = 1'b0;
        mul_result_tvalid = 1'b0;
        mul_result_tdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        arst_n = 1'b0;
        #1;
        check_reset_vals("reset");
        m_ptr = 0;
        m_done = 0;
        exp_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // driver: present a request set and expect the round-robin winner to be accepted
    task automatic do_request(input logic [N-1:0] mask, input logic [N*W-1:0] av,
                              input logic [N*W-1:0] bv);
        int pa, pb;
        @(negedge clk);
        req_tvalid  = mask;
        req_a_tdata = av;
        req_b_tdata = bv;
        #1;
        winner = rr_pick(mask, m_ptr);
        chk("req_tready", req_tready, 32'(1) << winner);
        pa = int'(av[winner*W +: W]);
        pb = int'(bv[winner*W +: W]);
        exp_q.push_back((2*W)'(pa * pb));
        @(posedge clk);
        #1;
        req_tvalid = '0;
        chk("busy_after_grant", busy, 1);
    endtask

    task automatic do_issue(input int a_dly, input int b_dly, input logic [W-1:0] ea,
                            input logic [W-1:0] eb);
        bit a_done = 0;
        bit b_done = 0;
        int c = 0;
        a_hs = 0;
        b_hs = 0;
        while (!(a_done && b_done)) begin
            chk("issue_a_valid", mul_a_tvalid, !a_done);
            chk("issue_b_valid", mul_b_tvalid, !b_done);
            if (!a_done) chk("issue_a_data", mul_a_tdata, ea);
            if (!b_done) chk("issue_b_data", mul_b_tdata, eb);
            chk("issue_res_ready", mul_result_tready, 0);
            mul_a_tready = (c >= a_dly);
            mul_b_tready = (c >= b_dly);
            mul_result_tvalid = 1'($urandom_range(0, 1));
            mul_result_tdata = (2*W)'($urandom);
            @(posedge clk);
            if (mul_a_tready) a_done = 1;
            if (mul_b_tready) b_done = 1;
            #1;
            c++;
        end
        mul_a_tready = 1'b0;
        mul_b_tready = 1'b0;
        mul_result_tvalid = 1'b0;
        chk("wait_res_ready", mul_result_tready, 1);
        chk("wait_ops_idle", {mul_a_tvalid, mul_b_tvalid}, 0);
        chk("a_handshakes", a_hs, 1);
        chk("b_handshakes", b_hs, 1);
    endtask

    task automatic do_result(input int r_dly);
        for (int d = 0; d < r_dly; d++) begin
            @(posedge clk);
            #1;
            chk("wait_hold", mul_result_tready, 1);
        end
        mul_result_tvalid = 1'b1;
        mul_result_tdata  = (2*W)'(int'(a_cap) * int'(b_cap));
        @(posedge clk);
        #1;
        mul_result_tvalid = 1'b0;
        mul_result_tdata  = (2*W)'($urandom);
    endtask

    task automatic do_respond(input int s_dly);
        logic [2*W-1:0] exp;
        logic [N-1:0] gbit;
        gbit = N'(1) << winner;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        chk("rsp_tvalid", rsp_tvalid, gbit);
        chk("rsp_tdata", rsp_tdata, exp);
        for (int d = 0; d < s_dly; d++) begin
            rsp_tready = ~gbit & N'($urandom);
            req_tvalid = N'($urandom);
            mul_result_tvalid = 1'b1;
            mul_result_tdata = (2*W)'($urandom);
            @(posedge clk);
            #1;
            chk("rsp_hold_valid", rsp_tvalid, gbit);
            chk("rsp_hold_data", rsp_tdata, exp);
            chk("rsp_hold_req_tready", req_tready, 0);
        end
        req_tvalid = '0;
        mul_result_tvalid = 1'b0;
        rsp_tready = gbit;
        @(posedge clk);
        #1;
        rsp_tready = '0;
        m_done++;
        m_ptr = (winner + 1) % N;
        chk("rsp_done_valid", rsp_tvalid, 0);
        chk("rsp_done_busy", busy, 0);
        chk("done_count", done_count, m_done);
    endtask

    task automatic txn(input logic [N-1:0] mask, input logic [N*W-1:0] av, input logic [N*W-1:0] bv,
                       input int ad, input int bd, input int rd, input int sd);
        do_request(mask, av, bv);
        do_issue(ad, bd, av[winner*W +: W], bv[winner*W +: W]);
        do_result(rd);
        do_respond(sd);
    endtask

    initial begin
        arst_n = 1'b0;
        req_a_tdata = '0;
        req_b_tdata = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        arst_n = 1'b1;

        // no requests: stays idle
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("idle_no_req", busy, 0);
        end

        // single requester 1, 3*3
        txn(4'b0010, 8'b0000_1100, 8'b0000_1100, 0, 0, 0, 0);

        // all four after reset, a=i, b=3, requests drop once served
        do_reset();
        txn(4'b1111, 8'b1110_0100, 8'hFF, 0, 0, 0, 0);
        txn(4'b1110, 8'b1110_0100, 8'hFF, 0, 0, 0, 0);
        txn(4'b1100, 8'b1110_0100, 8'hFF, 0, 0, 0, 0);
        txn(4'b1000, 8'b1110_0100, 8'hFF, 0, 0, 0, 0);

        // wrap: after serving 2, requesters 0 and 2 -> 0
        do_reset();
        txn(4'b0100, 8'b0010_0000, 8'b0011_0000, 0, 0, 1, 0);
        txn(4'b0101, 8'b0011_0010, 8'b0001_0011, 0, 0, 0, 0);

        // operand B stalled 5 cycles, A immediate
        txn(4'b0001, 8'h03, 8'h02, 0, 5, 2, 0);

        // response stalled 10 cycles
        txn(4'b0001, 8'h02, 8'h03, 1, 0, 0, 10);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, 15));
            txn(m, 8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // reset during WAIT: abort, late result ignored, pointer restarts at 0
        txn(4'b0010, 8'h04, 8'h04, 0, 0, 0, 0);
        do_request(4'b1000, 8'hC0, 8'h80);
        do_issue(0, 0, 2'd3, 2'd2);
        arst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        m_ptr = 0;
        m_done = 0;
        exp_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
        mul_result_tvalid = 1'b1;
        mul_result_tdata = 4'd5;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("late_result_busy", busy, 0);
            chk("late_result_rsp", rsp_tvalid, 0);
        end
        mul_result_tvalid = 1'b0;
        txn(4'b1010, 8'b1100_1000, 8'b0100_0100, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
